cactus_gen: RTL and testbench

Obstacle generator for the dinosaur game. It spawns up to two cacti at the right screen edge at pseudo-random spacing and scrolls them left once per frame. It answers the Vga block's per-pixel query with `px_cactus`. It sits directly upstream of Vga: it consumes Vga's `row_addr`, `col_addr` and `vs`, and feeds `px_cactus` back into Vga's pixel mux.

---
 rtl/cactus_gen.sv | 130 +++++++++++++
 tb/tb_cactus_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cactus_gen.sv
// Two-slot cactus spawner/scroller for the dino game; slot state moves once per frame on the vs rising edge.
// px_cactus is registered (1 vga_clk after row/col); no handshake, inputs sampled every cycle.
module cactus_gen #(
  parameter int CACTUS_W   = 16,
  parameter int TALL_H     = 32,
  parameter int SHORT_H    = 20,
  parameter int GROUND_ROW = 400,
  parameter int MIN_GAP    = 160
) (
  input  logic       vga_clk,
  input  logic       rst,
  input  logic       vs,
  input  logic       run,
  input  logic [3:0] speed,
  input  logic [8:0] row_addr,
  input  logic [9:0] col_addr,
  output logic       px_cactus,
  output logic [1:0] active
);

  localparam logic [10:0] SPAWN_X   = 11'(640 + CACTUS_W);
  localparam logic [10:0] WIDTH     = 11'(CACTUS_W);
  localparam logic [9:0]  ROW_END   = 10'(GROUND_ROW);
  localparam logic [9:0]  TOP_TALL  = 10'(GROUND_ROW - TALL_H);
  localparam logic [9:0]  TOP_SHORT = 10'(GROUND_ROW - SHORT_H);
  localparam logic [10:0] GAP_BASE  = 11'(MIN_GAP);
  localparam logic [15:0] SEED      = 16'hACE1;

  logic        vs_d;
  logic [1:0]  act;
  logic [10:0] xr [2];
  logic [1:0]  tall;
  logic [9:0]  gap;
  logic [15:0] lfsr;

  logic        upd;
  logic        step;
  logic [1:0]  mv_act;
  logic [10:0] mv_xr [2];
  logic [10:0] gap_sum;
  logic [9:0]  gap_next;
  logic [10:0] thr;
  logic        spawn;
  logic        spawn_slot;
  logic [15:0] lfsr_adv;
  logic [1:0]  nxt_act;
  logic [10:0] nxt_xr [2];
  logic [1:0]  nxt_tall;
  logic [10:0] lo [2];
  logic [9:0]  top [2];
  logic [1:0]  hit;

  assign upd  = vs & ~vs_d;
  assign step = upd & run & (speed != 4'd0);

  // Scroll or retire each live slot; retirement leaves xr as it was.
  always_comb begin
    mv_act = act;
    for (int i = 0; i < 2; i++) begin
      mv_xr[i] = xr[i];
      if (act[i]) begin
        if (xr[i] <= {7'd0, speed}) begin
          mv_act[i] = 1'b0;
        end else begin
          mv_xr[i] = xr[i] - {7'd0, speed};
        end
      end
    end
  end

  assign gap_sum    = {1'b0, gap} + {7'd0, speed};
  assign gap_next   = gap_sum[10] ? 10'd1023 : gap_sum[9:0];
  assign thr        = GAP_BASE + {3'd0, lfsr[7:0]};
  assign spawn      = ({1'b0, gap_next} >= thr) && (mv_act != 2'b11);
  assign spawn_slot = mv_act[0];
  assign lfsr_adv   = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  // A freshly spawned slot overrides its own motion result for this frame.
  always_comb begin
    nxt_act  = mv_act;
    nxt_tall = tall;
    for (int i = 0; i < 2; i++) begin
      nxt_xr[i] = mv_xr[i];
    end
    if (spawn) begin
      nxt_act[spawn_slot]  = 1'b1;
      nxt_xr[spawn_slot]   = SPAWN_X;
      nxt_tall[spawn_slot] = lfsr[8];
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      lo[i]  = (xr[i] >= WIDTH) ? (xr[i] - WIDTH) : 11'd0;
      top[i] = tall[i] ? TOP_TALL : TOP_SHORT;
      hit[i] = act[i]
             && ({1'b0, col_addr} >= lo[i]) && ({1'b0, col_addr} < xr[i])
             && ({1'b0, row_addr} >= top[i]) && ({1'b0, row_addr} < ROW_END);
    end
  end

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      vs_d      <= 1'b1;
      act       <= 2'b00;
      xr[0]     <= 11'd0;
      xr[1]     <= 11'd0;
      tall      <= 2'b00;
      gap       <= 10'd0;
      lfsr      <= SEED;
      px_cactus <= 1'b0;
    end else begin
      vs_d      <= vs;
      px_cactus <= |hit;
      if (step) begin
        act   <= nxt_act;
        xr[0] <= nxt_xr[0];
        xr[1] <= nxt_xr[1];
        tall  <= nxt_tall;
        gap   <= spawn ? 10'd0 : gap_next;
        if (spawn) begin
          lfsr <= lfsr_adv;
        end
      end
    end
  end

  assign active = act;

endmodule

// File: tb/tb_cactus_gen.sv
// Bench for cactus_gen: frame-level reference model checked every cycle, plus literal pins.
module tb_cactus_gen;

  logic       vga_clk = 1'b0;
  logic       rst;
  logic       vs;
  logic       run;
  logic [3:0] speed;
  logic [8:0] row_addr;
  logic [9:0] col_addr;
  logic       px_cactus;
  logic [1:0] active;

  cactus_gen dut (
    .vga_clk  (vga_clk),
    .rst      (rst),
    .vs       (vs),
    .run      (run),
    .speed    (speed),
    .row_addr (row_addr),
    .col_addr (col_addr),
    .px_cactus(px_cactus),
    .active   (active)
  );

  always #5 vga_clk = ~vga_clk;

  int n_total = 0;
  int n_pass  = 0;
  bit started = 0;

  // Reference state, plain integers.
  int         m_act [2];
  int         m_xr  [2];
  int         m_tall[2];
  int         m_gap;
  logic [15:0] m_lfsr;
  int         m_px;
  int         m_vs_d;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic int model_hit(input int row, input int col);
    int lo, h;
    for (int s = 0; s < 2; s++) begin
      lo = (m_xr[s] - 16 < 0) ? 0 : m_xr[s] - 16;
      h  = m_tall[s] ? 32 : 20;
      if (m_act[s] != 0 && col >= lo && col < m_xr[s] && row >= 400 - h && row < 400) return 1;
    end
    return 0;
  endfunction

  task automatic model_frame(input int sp);
    int g, thr, free;
    for (int s = 0; s < 2; s++) begin
      if (m_act[s] != 0) begin
        if (m_xr[s] <= sp) m_act[s] = 0;
        else m_xr[s] = m_xr[s] - sp;
      end
    end
    g    = (m_gap + sp > 1023) ? 1023 : m_gap + sp;
    thr  = 160 + int'(m_lfsr[7:0]);
    free = (m_act[0] == 0) ? 0 : ((m_act[1] == 0) ? 1 : -1);
    if (g >= thr && free >= 0) begin
      m_act[free]  = 1;
      m_xr[free]   = 656;
      m_tall[free] = int'(m_lfsr[8]);
      m_gap        = 0;
      m_lfsr       = lfsr_next(m_lfsr);
    end else begin
      m_gap = g;
    end
  endtask

  always @(posedge vga_clk) begin
    if (rst) begin
      m_act  = '{0, 0};
      m_xr   = '{0, 0};
      m_tall = '{0, 0};
      m_gap  = 0;
      m_lfsr = 16'hACE1;
      m_px   = 0;
      m_vs_d = 1;
    end else begin
      m_px = model_hit(int'(row_addr), int'(col_addr));
      if (vs && m_vs_d == 0 && run && speed != 0) model_frame(int'(speed));
      m_vs_d = int'(vs);
    end
  end

  always @(negedge vga_clk) begin
    if (started) begin
      check("px_model", {31'd0, px_cactus}, m_px[31:0]);
      check("active_model", {30'd0, active}, {30'd0, m_act[1] != 0, m_act[0] != 0});
    end
  end

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic probe_rand();
    int s, c;
    s = int'($urandom_range(0, 1));
    if (m_act[s] != 0) begin
      c = m_xr[s] - 18 + int'($urandom_range(0, 21));
      if (c < 0) c = 0;
      col_addr = 10'(c);
      row_addr = 9'($urandom_range(376, 402));
    end else begin
      col_addr = 10'($urandom_range(0, 639));
      row_addr = 9'($urandom_range(0, 479));
    end
  endtask

  task automatic frames(input int n);
    for (int f = 0; f < n; f++) begin
      vs = 1'b1;
      step();
      vs = 1'b0;
      for (int k = 0; k < 3; k++) begin
        probe_rand();
        step();
      end
    end
  endtask

  task automatic probe_lit(input string name, input int row, input int col, input logic want);
    row_addr = 9'(row);
    col_addr = 10'(col);
    @(posedge vga_clk);
    @(negedge vga_clk);
    check(name, {31'd0, px_cactus}, {31'd0, want});
  endtask

  initial begin
    int fs, fc;
    rst = 1'b1; vs = 1'b1; run = 1'b1; speed = 4'd2; row_addr = '0; col_addr = '0;
    @(posedge vga_clk);
    #1;
    started = 1;
    vs = 1'b0;
    step();
    vs = 1'b1;
    step();
    @(negedge vga_clk);
    check("reset_px", {31'd0, px_cactus}, 32'd0);
    check("reset_active", {30'd0, active}, 32'd0);
    rst = 1'b0;
    step();
    step();
    vs = 1'b0;
    step();

    frames(192);
    check("pre_spawn_active", {30'd0, active}, 32'd0);
    check("pre_spawn_gap", m_gap, 32'd384);
    frames(1);
    check("first_spawn_active", {30'd0, active}, 32'd1);
    check("first_spawn_xr", m_xr[0], 32'd656);
    check("first_spawn_tall", m_tall[0], 32'd0);
    check("first_spawn_gap", m_gap, 32'd0);
    check("first_spawn_lfsr", {16'd0, m_lfsr}, 32'h59C3);
    frames(1);
    check("scroll_xr", m_xr[0], 32'd654);
    probe_lit("pix_left_edge", 390, 638, 1'b1);
    probe_lit("pix_left_out", 390, 637, 1'b0);
    probe_lit("pix_right_edge", 390, 653, 1'b1);
    probe_lit("pix_right_out", 390, 654, 1'b0);
    probe_lit("pix_above_short", 379, 653, 1'b0);
    probe_lit("pix_top_short", 380, 653, 1'b1);
    probe_lit("pix_ground", 400, 645, 1'b0);

    frames(1);
    speed = 4'd4;
    frames(162);
    check("pre_retire_xr", m_xr[0], 32'd4);
    probe_lit("clamp_col0", 399, 0, 1'b1);
    probe_lit("clamp_col3", 399, 3, 1'b1);
    probe_lit("clamp_col4", 399, 4, 1'b0);
    frames(1);
    probe_lit("retired_col0", 399, 0, 1'b0);
    probe_lit("retired_col3", 399, 3, 1'b0);

    speed = 4'd5;
    frames(150);
    speed = 4'd15;
    frames(80);

    fs = (m_act[0] != 0) ? 0 : ((m_act[1] != 0) ? 1 : -1);
    if (fs >= 0) begin
      fc  = m_xr[fs] - 1;
      run = 1'b0;
      frames(10);
      probe_lit("freeze_run0", 399, fc, 1'b1);
      run = 1'b1; speed = 4'd0;
      frames(10);
      probe_lit("freeze_speed0", 399, fc, 1'b1);
      check("freeze_xr", m_xr[fs], fc + 1);
    end else begin
      run = 1'b0;
      frames(10);
      run = 1'b1; speed = 4'd0;
      frames(10);
      check("freeze_idle_active", {30'd0, active}, 32'd0);
    end
    speed = 4'd15;
    frames(40);

    vs = 1'b0;
    probe_rand();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge vga_clk);
    check("midframe_reset_active", {30'd0, active}, 32'd0);
    check("midframe_reset_px", {31'd0, px_cactus}, 32'd0);
    step();
    frames(60);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
